gated_hit_counter: RTL and testbench

GATED_HIT_COUNTER -- requirements
Module: gated_hit_counter

---
 rtl/gated_hit_counter_pkg.sv | 13 +
 rtl/gated_hit_counter_edge_sync.sv | 40 ++++
 rtl/gated_hit_counter.sv | 114 +++++++++++
 tb/tb_gated_hit_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gated_hit_counter_pkg.sv
// Shared constants for the gated hit counter: FSM state encodings and default gate length.
package gated_hit_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LATCH = 2'b10
    } state_t;

    localparam int unsigned DEFAULT_GATE_CYCLES = 100_000_000;
    localparam int          TIMER_WIDTH         = 32;

endpackage

// File: rtl/gated_hit_counter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A pin edge appears as a one-cycle pulse_out three clk cycles later.
module edge_sync
    import gated_hit_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/gated_hit_counter.sv
// Counts rising edges of an asynchronous hit input over a fixed-length gate
// opened by start; publishes a saturating count with a one-cycle valid strobe.
module gated_hit_counter
    import gated_hit_counter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   hit,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   valid,
    output logic                   busy,
    output logic                   overflow
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = GATE_CYCLES - 32'd1;
    localparam logic [COUNT_WIDTH-1:0] ACC_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] ACC_ONE    = COUNT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [COUNT_WIDTH-1:0]   acc_q,   acc_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     valid_q, valid_d;
    logic                     busy_q,  busy_d;
    logic                     ovf_q,   ovf_d;
    logic                     hit_evt;
    logic                     sync_rst;

    // Flushing the synchronizer in LATCH keeps late edges out of the next gate.
    assign sync_rst = rst | (state_q == LATCH);

    edge_sync u_edge_sync (
        .clk       (clk),
        .rst       (sync_rst),
        .async_in  (hit),
        .pulse_out (hit_evt)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        count_d = count_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    timer_d = TIMER_LOAD;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (hit_evt) begin
                    if (acc_q == ACC_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_q + ACC_ONE;
                    end
                end
                // The final RUN cycle's hit is folded into the published count.
                if (timer_q == '0) begin
                    state_d = LATCH;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    count_d = acc_d;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            LATCH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_gated_hit_counter.sv
// Self-checking bench: table-driven gates, hand-written corner sequences and
// random gates scored against a saturating-count reference.
module tb_gated_hit_counter;

    localparam int G  = 100;
    localparam int GB = 2000;
    localparam int W  = 8;
    localparam int CMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, hit = 1'b0;
    logic start_b = 1'b0, hit_b = 1'b0;
    logic [W-1:0] count, count_b;
    logic valid, busy, overflow;
    logic valid_b, busy_b, overflow_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gated_hit_counter #(.GATE_CYCLES(G), .COUNT_WIDTH(W)) dut_a (
        .clk(clk), .rst(rst), .start(start), .hit(hit),
        .count(count), .valid(valid), .busy(busy), .overflow(overflow)
    );

    gated_hit_counter #(.GATE_CYCLES(GB), .COUNT_WIDTH(W)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hit(hit_b),
        .count(count_b), .valid(valid_b), .busy(busy_b), .overflow(overflow_b)
    );

    typedef struct {
        int nh; int hi; int lo; int lead;
        bit pre; bit late; int start2;
        int exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic set_hit(input int sel, input bit v);
        if (sel != 0) hit_b = v; else hit = v;
    endtask

    task automatic set_start(input int sel, input bit v);
        if (sel != 0) start_b = v; else start = v;
    endtask

    // One full gate: optional pre-start hit, nh pulses of hi/lo cycles from cycle lead,
    // optional hit landing in LATCH, optional extra start at RUN cycle start2.
    task automatic gate(input int sel, input int nh, input int hi, input int lo, input int lead,
                        input bit pre, input bit late, input int start2,
                        output int bcy, output int vcy, output int vat,
                        output int cnt, output int ov, output int ov0);
        int gl;
        int per;
        bit h;
        gl  = (sel != 0) ? GB : G;
        per = hi + lo;
        if (pre) begin
            set_hit(sel, 1'b1);
            tick();
            tick();
        end
        set_start(sel, 1'b1);
        tick();
        set_start(sel, 1'b0);
        set_hit(sel, 1'b0);
        bcy = 0; vcy = 0; vat = -1; cnt = -1; ov = -1; ov0 = -1;
        for (int t = 0; t < gl + 12; t++) begin
            if (t == 0) ov0 = int'((sel != 0) ? overflow_b : overflow);
            if ((sel != 0) ? busy_b : busy) bcy++;
            if ((sel != 0) ? valid_b : valid) begin
                vcy++;
                vat = t;
                cnt = int'((sel != 0) ? count_b : count);
                ov  = int'((sel != 0) ? overflow_b : overflow);
            end
            h = (nh > 0) && (t >= lead) && (t - lead < nh * per) && ((t - lead) % per < hi);
            if (late && t >= gl - 3 && t <= gl) h = 1'b1;
            set_hit(sel, h);
            set_start(sel, t == start2);
            tick();
        end
        set_hit(sel, 1'b0);
        set_start(sel, 1'b0);
    endtask

    task automatic score(input string tag, input int sel, input int exp_cnt, input int exp_ov,
                         input int bcy, input int vcy, input int vat,
                         input int cnt, input int ov, input int ov0);
        int gl;
        gl = (sel != 0) ? GB : G;
        check({tag, " count"},     32'(cnt), 32'(exp_cnt));
        check({tag, " overflow"},  32'(ov),  32'(exp_ov));
        check({tag, " valids"},    32'(vcy), 32'd1);
        check({tag, " busy_cyc"},  32'(bcy), 32'(gl));
        check({tag, " valid_at"},  32'(vat), 32'(gl));
        check({tag, " ovf_clr"},   32'(ov0), 32'd0);
    endtask

    initial begin
        int bcy, vcy, vat, cnt, ov, ov0;
        int nh, hi, lo, lead, maxnh, exp_cnt, exp_ov;

        vecs[0] = '{nh:10, hi:4, lo:4, lead:2,  pre:0, late:0, start2:-1, exp_cnt:10};
        vecs[1] = '{nh:0,  hi:4, lo:4, lead:0,  pre:0, late:0, start2:-1, exp_cnt:0};
        vecs[2] = '{nh:5,  hi:2, lo:2, lead:0,  pre:0, late:0, start2:-1, exp_cnt:5};
        vecs[3] = '{nh:20, hi:2, lo:2, lead:10, pre:0, late:0, start2:-1, exp_cnt:20};
        vecs[4] = '{nh:3,  hi:4, lo:4, lead:5,  pre:0, late:0, start2:50, exp_cnt:3};
        vecs[5] = '{nh:0,  hi:4, lo:4, lead:0,  pre:1, late:1, start2:-1, exp_cnt:1};
        vecs[6] = '{nh:0,  hi:4, lo:4, lead:0,  pre:0, late:0, start2:-1, exp_cnt:0};
        vecs[7] = '{nh:12, hi:3, lo:5, lead:0,  pre:0, late:0, start2:-1, exp_cnt:12};

        // Reset state
        tick(); tick(); tick();
        check("rst count_a", 32'(count), 32'd0);
        check("rst valid_a", 32'(valid), 32'd0);
        check("rst busy_a",  32'(busy),  32'd0);
        check("rst ovf_a",   32'(overflow), 32'd0);
        check("rst count_b", 32'(count_b), 32'd0);
        check("rst busy_b",  32'(busy_b),  32'd0);
        rst = 1'b0;

        // Table-driven gates
        for (int i = 0; i < 8; i++) begin
            gate(0, vecs[i].nh, vecs[i].hi, vecs[i].lo, vecs[i].lead,
                 vecs[i].pre, vecs[i].late, vecs[i].start2, bcy, vcy, vat, cnt, ov, ov0);
            score($sformatf("vec%0d", i), 0, vecs[i].exp_cnt, 0, bcy, vcy, vat, cnt, ov, ov0);
        end

        // Saturation, then the next start clears overflow
        gate(1, 300, 2, 2, 0, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
        score("sat", 1, CMAX, 1, bcy, vcy, vat, cnt, ov, ov0);
        gate(1, 10, 2, 2, 3, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
        score("sat_next", 1, 10, 0, bcy, vcy, vat, cnt, ov, ov0);

        // Reset mid-RUN with start and hit asserted alongside it
        gate(0, 7, 4, 4, 0, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
        score("pre_rst", 0, 7, 0, bcy, vcy, vat, cnt, ov, ov0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 40; t++) begin
            hit = (t < 40) && (t % 8 < 4);
            tick();
        end
        rst = 1'b1; start = 1'b1; hit = 1'b1;
        tick();
        check("midrst count", 32'(count), 32'd0);
        check("midrst busy",  32'(busy),  32'd0);
        check("midrst valid", 32'(valid), 32'd0);
        check("midrst ovf",   32'(overflow), 32'd0);
        rst = 1'b0; start = 1'b0; hit = 1'b0;
        gate(0, 2, 4, 4, 3, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
        score("post_rst", 0, 2, 0, bcy, vcy, vat, cnt, ov, ov0);

        // Glitchy 1-cycle pulses
        gate(0, 20, 1, 1, 0, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
        check("glitch le", 32'(cnt <= 20 && cnt >= 0), 32'd1);
        check("glitch valids", 32'(vcy), 32'd1);
        check("glitch noX", 32'($isunknown({count, valid, busy, overflow})), 32'd0);

        // Random gates against the saturating reference
        for (int i = 0; i < 24; i++) begin
            hi    = $urandom_range(2, 5);
            lo    = $urandom_range(2, 5);
            lead  = $urandom_range(0, 5);
            maxnh = (G - 1 - 3 - lead) / (hi + lo) + 1;
            nh    = $urandom_range(0, maxnh);
            gate(0, nh, hi, lo, lead, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
            score($sformatf("rnd_a%0d n=%0d", i, nh), 0, nh, 0, bcy, vcy, vat, cnt, ov, ov0);
        end
        for (int i = 0; i < 2; i++) begin
            hi    = 2;
            lo    = $urandom_range(2, 3);
            lead  = $urandom_range(0, 5);
            maxnh = (GB - 1 - 3 - lead) / (hi + lo) + 1;
            nh    = $urandom_range(200, maxnh);
            exp_cnt = (nh > CMAX) ? CMAX : nh;
            exp_ov  = (nh > CMAX) ? 1 : 0;
            gate(1, nh, hi, lo, lead, 0, 0, -1, bcy, vcy, vat, cnt, ov, ov0);
            score($sformatf("rnd_b%0d n=%0d", i, nh), 1, exp_cnt, exp_ov, bcy, vcy, vat, cnt, ov, ov0);
        end

        // Start and hit coinciding with reset
        rst = 1'b1; start = 1'b1; hit = 1'b1; start_b = 1'b1; hit_b = 1'b1;
        tick();
        check("rst_start count", 32'(count), 32'd0);
        check("rst_start busy",  32'(busy),  32'd0);
        check("rst_start valid", 32'(valid), 32'd0);
        check("rst_start ovf",   32'(overflow), 32'd0);
        check("rst_start b",     32'({count_b, valid_b, busy_b, overflow_b}), 32'd0);
        rst = 1'b0; start = 1'b0; hit = 1'b0; start_b = 1'b0; hit_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
